display_arbiter: RTL and testbench

Shares the four-digit seven-segment display between two independent data sources, for example the Gray counter value and a status or diagnostic byte. It drives the 8-bit data input of the LED driver and runs a registered round-robin request/grant handshake. A minimum-ownership timer stops the display from flickering between sources. When no source requests the display, it shows a fixed idle pattern.

---
 rtl/display_arbiter.sv | 115 +++++++++++
 tb/tb_display_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// Round-robin owner of the shared seven-segment display between two byte sources.
// Grants are registered, a minimum-ownership timer limits preemption, and idle shows a fixed pattern.
module display_arbiter #(
  parameter int          HOLD_CYCLES = 4,
  parameter logic [7:0]  IDLE_DATA   = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [7:0] Data_out,
  output logic       busy,
  output logic       changed
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic          last;
  logic          last_next;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_next;
  logic [7:0]    data_next;

  // An owner dropping its request always wins over the hold timer; preemption needs an expired timer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req0 && req1)
          state_next = last ? OWN0 : OWN1;
        else if (req0)
          state_next = OWN0;
        else if (req1)
          state_next = OWN1;
        else
          state_next = IDLE;
      end
      OWN0: begin
        if (!req0)
          state_next = req1 ? OWN1 : IDLE;
        else if ((hold_cnt == '0) && req1)
          state_next = OWN1;
        else
          state_next = OWN0;
      end
      OWN1: begin
        if (!req1)
          state_next = req0 ? OWN0 : IDLE;
        else if ((hold_cnt == '0) && req0)
          state_next = OWN0;
        else
          state_next = OWN1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    hold_next = hold_cnt;
    last_next = last;
    if (state_next == IDLE) begin
      hold_next = '0;
    end else if (state_next != state) begin
      hold_next = HOLD_LOAD;
      last_next = (state_next == OWN1);
    end else if (hold_cnt != '0) begin
      hold_next = hold_cnt - HOLD_ONE;
    end
  end

  always_comb begin
    data_next = IDLE_DATA;
    case (state_next)
      OWN0:    data_next = data0;
      OWN1:    data_next = data1;
      default: data_next = IDLE_DATA;
    endcase
  end

  // Outputs come from next-state so grant, data and the change pulse line up on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      hold_cnt <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      busy     <= 1'b0;
      changed  <= 1'b0;
      Data_out <= IDLE_DATA;
    end else begin
      state    <= state_next;
      last     <= last_next;
      hold_cnt <= hold_next;
      gnt0     <= (state_next == OWN0);
      gnt1     <= (state_next == OWN1);
      busy     <= (state_next != IDLE);
      changed  <= (state_next != state);
      Data_out <= data_next;
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter: a driver pushes model predictions, a monitor pops and compares.
// The reference model tracks the owner as an integer and counts cycles owned upward.
module tb_display_arbiter;

  localparam int         HOLD = 4;
  localparam logic [7:0] IDLE_PAT = 8'h00;

  typedef struct packed {
    logic       g0;
    logic       g1;
    logic       busy;
    logic       chg;
    logic [7:0] data;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       req0;
  logic [7:0] data0;
  logic       req1;
  logic [7:0] data1;
  logic       gnt0;
  logic       gnt1;
  logic [7:0] Data_out;
  logic       busy;
  logic       changed;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  bit   started = 0;
  bit   done = 0;

  int   owner = -1;
  int   last_m = 1;
  int   owned_for = 0;

  display_arbiter #(.HOLD_CYCLES(HOLD), .IDLE_DATA(IDLE_PAT)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .Data_out(Data_out), .busy(busy), .changed(changed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of inputs on the falling edge and queue the outputs expected after the next rising edge.
  task automatic apply_stimulus(input bit rst_n, input bit r0, input logic [7:0] d0,
                                input bit r1, input logic [7:0] d1);
    exp_t e;
    int   nxt;
    bit   prev_rst;
    @(negedge clock);
    prev_rst = reset;
    reset = rst_n;
    req0  = r0;
    data0 = d0;
    req1  = r1;
    data1 = d1;
    if (!rst_n) begin
      owner = -1;
      last_m = 1;
      owned_for = 0;
      e = '{g0: 1'b0, g1: 1'b0, busy: 1'b0, chg: 1'b0, data: IDLE_PAT};
      if (prev_rst) begin
        #1;
        check_output("async_reset", e);
      end
    end else begin
      if (owner < 0) begin
        if (r0 && r1)      nxt = 1 - last_m;
        else if (r0)       nxt = 0;
        else if (r1)       nxt = 1;
        else               nxt = -1;
      end else begin
        bit own_req   = (owner == 0) ? r0 : r1;
        bit other_req = (owner == 0) ? r1 : r0;
        if (!own_req)                               nxt = other_req ? 1 - owner : -1;
        else if (other_req && owned_for >= HOLD)    nxt = 1 - owner;
        else                                        nxt = owner;
      end
      e.g0   = (nxt == 0);
      e.g1   = (nxt == 1);
      e.busy = (nxt >= 0);
      e.chg  = (nxt != owner);
      e.data = (nxt == 0) ? d0 : (nxt == 1) ? d1 : IDLE_PAT;
      if (nxt >= 0 && nxt != owner) begin
        last_m = nxt;
        owned_for = 1;
      end else if (nxt >= 0) begin
        if (owned_for < 1000) owned_for++;
      end else begin
        owned_for = 0;
      end
      owner = nxt;
    end
    exp_q.push_back(e);
    started = 1;
  endtask

  task automatic check_output(input string name, input exp_t e);
    exp_t act;
    act = '{g0: gnt0, g1: gnt1, busy: busy, chg: changed, data: Data_out};
    compared++;
    if (act !== e) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got gnt0=%b gnt1=%b busy=%b changed=%b data=%h, expected gnt0=%b gnt1=%b busy=%b changed=%b data=%h",
               name, $time, act.g0, act.g1, act.busy, act.chg, act.data,
               e.g0, e.g1, e.busy, e.chg, e.data);
    end
  endtask

  // Monitor: one prediction is consumed just after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("cycle", e);
      end else if (started && !done) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL scoreboard_empty at %0t: got no prediction, expected one", $time);
      end
    end
  end

  initial begin
    reset = 1'b0;
    req0 = 1'b0; data0 = 8'h00;
    req1 = 1'b0; data1 = 8'h00;

    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b0, 1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
    for (int i = 0; i < 2; i++)
      apply_stimulus(1'b1, 1'b0, 8'h33, 1'b0, 8'h44);

    apply_stimulus(1'b1, 1'b1, 8'h5A, 1'b0, 8'h00);
    apply_stimulus(1'b1, 1'b1, 8'hA5, 1'b0, 8'h00);
    apply_stimulus(1'b1, 1'b1, 8'hA5, 1'b0, 8'h00);
    apply_stimulus(1'b1, 1'b0, 8'hA5, 1'b0, 8'h00);
    apply_stimulus(1'b1, 1'b0, 8'hA5, 1'b0, 8'h00);

    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 14; i++)
      apply_stimulus(1'b1, 1'b1, 8'h10 + 8'(i), 1'b1, 8'h80 + 8'(i));
    apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

    apply_stimulus(1'b1, 1'b1, 8'h01, 1'b0, 8'h02);
    apply_stimulus(1'b1, 1'b1, 8'h01, 1'b1, 8'h02);
    apply_stimulus(1'b1, 1'b0, 8'h01, 1'b1, 8'h03);
    apply_stimulus(1'b1, 1'b0, 8'h01, 1'b1, 8'h04);
    apply_stimulus(1'b1, 1'b0, 8'h01, 1'b0, 8'h04);
    apply_stimulus(1'b1, 1'b0, 8'h01, 1'b0, 8'h04);

    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b1, 1'b0, 8'h00, 1'b1, 8'hC3);
    apply_stimulus(1'b0, 1'b1, 8'h11, 1'b1, 8'hC3);
    apply_stimulus(1'b1, 1'b1, 8'h11, 1'b1, 8'h22);
    apply_stimulus(1'b1, 1'b1, 8'h11, 1'b1, 8'h22);

    for (int i = 0; i < 500; i++) begin
      bit rst_n = ($urandom_range(0, 59) != 0);
      bit r0 = ($urandom_range(0, 3) != 0);
      bit r1 = ($urandom_range(0, 3) != 0);
      apply_stimulus(rst_n, r0, 8'($urandom), r1, 8'($urandom));
    end
    apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

    @(posedge clock);
    #3;
    done = 1;
    repeat (2) @(posedge clock);
    #2;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover predictions, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
